// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out deserialiser.
package sipo_pkg;

  typedef enum logic {MSB_FIRST = 1'b0, LSB_FIRST = 1'b1} bit_order_e;

  localparam int SIPO_DEFAULT_WIDTH = 8;

  typedef enum logic {HOLD_EMPTY = 1'b0, HOLD_FULL = 1'b1} hold_state_e;

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register for assembled words, with a sticky
// flag for words that arrive while the entry is still owned downstream.
module sipo_hold_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  hold_state_e      state_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             ovr_q;
  logic             ovr_d;
  logic             ovr_set_s;

  // A completed word is lost only when the entry is full and not draining this edge.
  always_comb begin
    ovr_set_s = 1'b0;
    ovr_d     = ovr_q;
    if (wr_en && (state_q == HOLD_FULL) && !rd_ready) begin
      ovr_set_s = 1'b1;
    end else begin
      ovr_set_s = 1'b0;
    end
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Holding-register state machine; dout only changes on load or reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HOLD_EMPTY;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        HOLD_EMPTY: begin
          if (wr_en) begin
            state_q <= HOLD_FULL;
            valid_q <= 1'b1;
            dout_q  <= wr_data;
          end
        end
        HOLD_FULL: begin
          if (rd_ready && wr_en) begin
            dout_q <= wr_data;
          end else if (rd_ready) begin
            state_q <= HOLD_EMPTY;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= HOLD_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser: qualified shift-in, bit counting and a
// one-word valid/ready output buffer.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter  int         WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter  bit_order_e BIT_ORDER = MSB_FIRST,
  localparam int         CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] shifted_s;
  logic             word_done_s;

  // Next shift/count state; the completed word is the post-shift value.
  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    word_done_s = 1'b0;
    if (BIT_ORDER == MSB_FIRST) begin
      shifted_s = {sr_q[WIDTH-2:0], din};
    end else begin
      shifted_s = {din, sr_q[WIDTH-1:1]};
    end
    if (sync_clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (din_valid) begin
      sr_d = shifted_s;
      if (cnt_q == LAST_CNT) begin
        cnt_d       = '0;
        word_done_s = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  sipo_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (word_done_s),
    .wr_data   (shifted_s),
    .rd_ready  (dout_ready),
    .ovr_clr   (ovr_clr),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overrun   (overrun)
  );

  assign bit_cnt = cnt_q;

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-in/parallel-out deserialiser with qualified input, bit counting, and a one-word valid/ready output buffer. It collects WIDTH serial bits into a word, hands the word downstream through a holding register, and flags words lost to back-pressure. It replaces the fixed 4-bit SIPO in serial receive paths such as UART/SPI front ends and test-pattern capture.

## Interface
- WIDTH, 8, word length in bits; must be ≥ 2
- BIT_ORDER, MSB_FIRST, bit_order_e; selects whether the first received bit lands in dout[WIDTH-1] or dout[0]
- CNT_W, $clog2(WIDTH), localparam; width of the bit counter

- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  asynchronous, active-low reset
- din  in  1  serial data bit
- din_valid  in  1  din is sampled on this edge
- sync_clr  in  1  synchronous framing restart; discards the partial word
- dout  out  WIDTH  assembled word from the holding register
- dout_valid  out  1  holding register is full
- dout_ready  in  1  downstream accepts dout this cycle
- bit_cnt  out  CNT_W  number of bits in the partial word
- overrun  out  1  sticky flag; a completed word was dropped
- ovr_clr  in  1  clears overrun

## Operation
- Reset (rst=0) takes effect immediately. Shift register, bit_cnt, dout, dout_valid and overrun all go to 0.
- Shifting occurs on each edge with din_valid=1 and sync_clr=0:
  - MSB_FIRST: sr ← {sr[WIDTH-2:0], din}.
  - LSB_FIRST: sr ← {din, sr[WIDTH-1:1]}.
  - bit_cnt increments by 1.
- Gaps in din_valid hold sr and bit_cnt unchanged.
- Word completes on a shift with bit_cnt = WIDTH-1. The assembled word is the post-shift value. bit_cnt wraps to 0 and sr need not clear.
- The holding register is a two-state machine:
  - EMPTY → FULL on word completion.
  - FULL → EMPTY on handshake (dout_valid & dout_ready) with no completion.
  - FULL → FULL with reload when handshake and completion occur on the same edge.
  - FULL with completion and no handshake: the new word is dropped, dout is unchanged, and overrun ← 1.
- dout is stable while dout_valid=1 and no handshake has occurred.
- sync_clr sets bit_cnt ← 0 and sr ← 0. It has priority over din_valid on the same edge, so that bit is discarded. It does not affect dout, dout_valid or overrun.
- overrun stays set until ovr_clr. If a set and ovr_clr occur on the same edge, set wins.
- No arithmetic beyond bit_cnt increment and wrap at WIDTH-1. Non-power-of-2 WIDTH is legal.

## Timing
- Latency: dout_valid rises on the edge that samples the final bit. It is visible in the cycle after that bit was presented.
- Throughput: one word per WIDTH valid bits. Back-to-back words with dout_ready held at 1 lose nothing.
- dout_ready may be asserted before dout_valid, and it has no effect while EMPTY.
- No combinational path from any input to any output. All outputs are registered.

## Structure
- Shared package sipo_pkg holds:
  - typedef enum logic {MSB_FIRST, LSB_FIRST} bit_order_e
  - SIPO_DEFAULT_WIDTH = 8
  - typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_e
- One sub-module: sipo_hold_reg.
  - Parametrised by WIDTH.
  - Implements the one-entry valid/ready buffer and the overrun-set pulse.
- Shift/count logic stays in sipo_deser.

## Test plan
- Reset: drive rst=0 after 5 valid bits → bit_cnt, dout, dout_valid and overrun are 0 immediately (no clock edge). After release, 8 bits produce a full word.
- MSB_FIRST, WIDTH=8, dout_ready=1, bits 1,1,0,1,0,0,0,0 → dout=8'hD0 with a single-cycle dout_valid after the 8th bit. Repeat with LSB_FIRST → dout=8'h0B.
- Gapped input: same 8 bits with din_valid low for 3 cycles between bits 4 and 5 → bit_cnt holds at 4 during the gap, and dout=8'hD0 as before.
- Back-pressure: dout_ready=0, words 8'h3C then 8'hA5 → dout stays 8'h3C and overrun=1. Then dout_ready=1 for one cycle → dout_valid=0. Then ovr_clr → overrun=0.
- Same-edge handshake and completion: dout_ready pulses on the edge the 8th bit of 8'h5A lands while 8'h3C is held → dout_valid stays 1, dout=8'h5A, overrun=0.
- sync_clr: assert with din_valid=1 after 5 bits → bit_cnt=0 next cycle and the bit is discarded. The next 8 bits 0,1,0,1,1,0,1,0 (MSB_FIRST) → dout=8'h5A.
